// File: rtl/mystery2_unscrambler.sv
// Unscrambler for the 4-phase scrambled word stream: tracks phase, recovers (alpha, beta)
// pairs into a small FIFO with registered head outputs, and checks each word against the stream rules.
module mystery2_unscrambler #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [15:0] in_word,
    output logic [15:0] pair_data,
    output logic        pair_first,
    output logic        pair_valid,
    input  logic        pair_ready,
    output logic        err,
    output logic [7:0]  err_count,
    output logic        overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        PH_NIB   = 2'd0,
        PH_SWAP  = 2'd1,
        PH_ALPHA = 2'd2,
        PH_BETA  = 2'd3
    } phase_t;

    phase_t          phase_r;
    logic            first_r;
    logic [15:0]     prev_r;
    logic [7:0]      alpha_r;
    logic [16:0]     mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic [15:0]     pred_s;
    logic [15:0]     mask_s;
    logic            mismatch_s;
    logic            push_s;
    logic [16:0]     push_entry_s;
    logic            pop_s;
    logic            full_s;
    logic            write_s;
    logic            drop_s;
    logic [AW-1:0]   wr_ptr_nx_s;
    logic [AW-1:0]   rd_ptr_nx_s;
    logic [CW-1:0]   count_nx_s;
    logic [16:0]     head_s;

    function automatic logic [15:0] nibble_reverse(input logic [15:0] w);
        return {w[3:0], w[7:4], w[11:8], w[15:12]};
    endfunction

    // Predicted word and the mask of bits that are actually predictable this phase
    always_comb begin
        pred_s = 16'h0000;
        mask_s = 16'h0000;
        if (first_r) begin
            pred_s = 16'h0000;
            mask_s = 16'h0000;
        end else begin
            case (phase_r)
                PH_SWAP: begin
                    pred_s = {prev_r[7:0], prev_r[15:8]};
                    mask_s = 16'hFFFF;
                end
                PH_ALPHA: begin
                    pred_s = {prev_r[7:0], 8'h00};
                    mask_s = 16'hFF00;
                end
                PH_BETA: begin
                    pred_s = {8'h00, prev_r[15:8]};
                    mask_s = 16'h00FF;
                end
                PH_NIB: begin
                    pred_s = nibble_reverse(prev_r);
                    mask_s = 16'hFFFF;
                end
                default: begin
                    pred_s = 16'h0000;
                    mask_s = 16'h0000;
                end
            endcase
        end
        mismatch_s   = |((in_word ^ pred_s) & mask_s);
        push_s       = first_r || (phase_r == PH_BETA);
        push_entry_s = first_r ? {1'b1, in_word} : {1'b0, alpha_r, in_word[15:8]};
    end

    // FIFO bookkeeping; the head is looked up from next-state pointers so outputs can be registered
    always_comb begin
        pop_s       = pair_valid && pair_ready;
        full_s      = (count_r == FULL_CNT);
        write_s     = push_s && (!full_s || pop_s);
        drop_s      = push_s && full_s && !pop_s;
        wr_ptr_nx_s = write_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
        rd_ptr_nx_s = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
        case ({write_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
        // An empty-after-pop FIFO receiving a write presents the incoming entry directly
        if (write_s && (rd_ptr_nx_s == wr_ptr_r)) begin
            head_s = push_entry_s;
        end else begin
            head_s = mem_r[rd_ptr_nx_s];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (nReset && write_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Phase tracking, recovery, checking and registered FIFO head
    always_ff @(posedge clk) begin
        if (!nReset) begin
            phase_r    <= PH_NIB;
            first_r    <= 1'b1;
            prev_r     <= 16'h0000;
            alpha_r    <= 8'h00;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            pair_valid <= 1'b0;
            pair_data  <= 16'h0000;
            pair_first <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            phase_r  <= phase_t'(phase_r + 2'd1);
            first_r  <= 1'b0;
            prev_r   <= in_word;
            if (!first_r && (phase_r == PH_ALPHA)) begin
                alpha_r <= in_word[7:0];
            end
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            count_r  <= count_nx_s;
            if (count_nx_s != '0) begin
                pair_valid <= 1'b1;
                pair_data  <= head_s[15:0];
                pair_first <= head_s[16];
            end else begin
                pair_valid <= 1'b0;
                pair_data  <= 16'h0000;
                pair_first <= 1'b0;
            end
            if (mismatch_s) begin
                err <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mystery2_unscrambler.sv
// Bench for mystery2_unscrambler: a rule-level stream generator plus a queue-based reference
// model of recovery, checking and FIFO behaviour, compared against the DUT every step.
module tb_mystery2_unscrambler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] in_word = 16'h0000;
    logic        pair_ready = 1'b0;
    logic [15:0] pair_data;
    logic        pair_first;
    logic        pair_valid;
    logic        err;
    logic [7:0]  err_count;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    int          m_n;
    logic [15:0] m_prev;
    logic [7:0]  m_alpha;
    logic [16:0] q[$];
    logic        m_err;
    int          m_cnt;
    logic        m_ovf;
    logic [15:0] last_w;

    mystery2_unscrambler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .nReset(nReset), .in_word(in_word),
        .pair_data(pair_data), .pair_first(pair_first), .pair_valid(pair_valid),
        .pair_ready(pair_ready), .err(err), .err_count(err_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    // Word the stream rules produce after prev at index n; fresh supplies the new bytes.
    function automatic logic [15:0] rule_word(input logic [15:0] prev, input int n, input logic [15:0] fresh);
        logic [15:0] r;
        r = fresh;
        if (n != 0) begin
            case (n % 4)
                1: r = {prev[7:0], prev[15:8]};
                2: r = {prev[7:0], fresh[7:0]};
                3: r = {fresh[15:8], prev[15:8]};
                default: for (int k = 0; k < 4; k++) r[4*k +: 4] = prev[4*(3-k) +: 4];
            endcase
        end
        return r;
    endfunction

    task automatic step(input logic [15:0] w, input logic rdy, input logic rst_n);
        in_word = w;
        pair_ready = rdy;
        nReset = rst_n;
        last_w = w;
        @(posedge clk);
        if (!rst_n) begin
            m_n = 0; m_prev = 16'h0000; m_alpha = 8'h00;
            q.delete(); m_err = 1'b0; m_cnt = 0; m_ovf = 1'b0;
        end else begin
            if (rdy && q.size() > 0) q.delete(0);
            if (m_n == 0 || m_n % 4 == 3) begin
                if (q.size() < DEPTH) q.push_back((m_n == 0) ? {1'b1, w} : {1'b0, m_alpha, w[15:8]});
                else m_ovf = 1'b1;
            end
            // Feeding w as the fresh bytes makes only the rule-determined bits count
            if (m_n > 0 && w != rule_word(m_prev, m_n, w)) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (m_n % 4 == 2) m_alpha = w[7:0];
            m_prev = w;
            m_n++;
        end
        #1;
    endtask

    task automatic gen_step(input logic rdy, input logic corrupt);
        logic [15:0] w;
        w = rule_word(m_prev, m_n, 16'($urandom));
        if (corrupt) w = w ^ 16'hFFFF;
        step(w, rdy, 1'b1);
    endtask

    task automatic test_reset;
        step(16'h1234, 1'b0, 1'b0);
        tests++; if (pair_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", pair_valid); end
        tests++; if (pair_data !== 16'h0000) begin fails++; $display("FAIL reset_data got %h want 0000", pair_data); end
        tests++; if (pair_first !== 1'b0) begin fails++; $display("FAIL reset_first got %b want 0", pair_first); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    endtask

    task automatic test_directed(input logic bad);
        logic [15:0] words [5];
        words = '{16'h1234, 16'h3412, 16'h1256, 16'h7812, 16'h2187};
        if (bad) words[1] = 16'h3413;
        step(16'h1234, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(words[i], 1'b1, 1'b1);
            tests++; if (pair_valid !== (q.size() != 0)) begin fails++; $display("FAIL dir_valid step %0d got %b want %b", i, pair_valid, q.size() != 0); end
            tests++; if (err !== m_err || err_count !== 8'(m_cnt)) begin fails++; $display("FAIL dir_err step %0d got %b/%0d want %b/%0d", i, err, err_count, m_err, m_cnt); end
            if (i == 0) begin
                tests++; if (pair_valid !== 1'b1 || pair_data !== 16'h1234 || pair_first !== 1'b1) begin fails++; $display("FAIL dir_pair0 got %b %h %b want 1 1234 1", pair_valid, pair_data, pair_first); end
            end else if (i == 3) begin
                tests++; if (pair_valid !== 1'b1 || pair_data !== 16'h5678 || pair_first !== 1'b0) begin fails++; $display("FAIL dir_pair1 got %b %h %b want 1 5678 0", pair_valid, pair_data, pair_first); end
            end else if (i == 1 && bad) begin
                tests++; if (err !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL mismatch_edge1 got %b/%0d want 1/1", err, err_count); end
            end else if (!bad) begin
                tests++; if (err !== 1'b0) begin fails++; $display("FAIL dir_no_err step %0d got %b want 0", i, err); end
            end
        end
    endtask

    task automatic test_overflow;
        step(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) gen_step(1'b0, 1'b0);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
        tests++; if (q.size() != DEPTH || pair_valid !== 1'b1 || pair_first !== 1'b1) begin fails++; $display("FAIL ovf_head got %b/%b want 1/1", pair_valid, pair_first); end
        for (int i = 0; i < 8; i++) begin
            gen_step(1'b1, 1'b0);
            tests++; if (pair_valid !== (q.size() != 0)) begin fails++; $display("FAIL ovf_drain_valid %0d got %b want %b", i, pair_valid, q.size() != 0); end
            if (q.size() != 0) begin
                tests++; if (pair_data !== q[0][15:0] || pair_first !== q[0][16]) begin fails++; $display("FAIL ovf_drain_data %0d got %h/%b want %h/%b", i, pair_data, pair_first, q[0][15:0], q[0][16]); end
            end
        end
    endtask

    task automatic test_full_push_pop;
        step(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) gen_step(1'b0, 1'b0);
        gen_step(1'b1, 1'b0);
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpp_overflow got %b want 0", overflow); end
        tests++; if (int'(dut.count_r) != 4) begin fails++; $display("FAIL fullpp_occupancy got %0d want 4", dut.count_r); end
        for (int i = 0; i < 6; i++) begin
            gen_step(1'b1, 1'b0);
            tests++; if (pair_valid !== (q.size() != 0)) begin fails++; $display("FAIL fullpp_valid %0d got %b want %b", i, pair_valid, q.size() != 0); end
            if (q.size() != 0) begin
                tests++; if (pair_data !== q[0][15:0] || pair_first !== q[0][16]) begin fails++; $display("FAIL fullpp_data %0d got %h/%b want %h/%b", i, pair_data, pair_first, q[0][15:0], q[0][16]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        step(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) gen_step(1'b0, 1'b1);
        tests++; if (q.size() != 2 || pair_valid !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL mid_pre got %b/%b want 1/1", pair_valid, err); end
        step(16'($urandom), 1'b0, 1'b0);
        tests++; if ({pair_valid, pair_first, pair_data, err, err_count, overflow} !== 28'h0) begin fails++; $display("FAIL mid_reset_zero got %b %b %h %b %0d %b want all 0", pair_valid, pair_first, pair_data, err, err_count, overflow); end
        gen_step(1'b0, 1'b0);
        tests++; if (pair_valid !== 1'b1 || pair_first !== 1'b1 || pair_data !== last_w) begin fails++; $display("FAIL mid_first_pair got %b %b %h want 1 1 %h", pair_valid, pair_first, pair_data, last_w); end
    endtask

    task automatic test_saturate;
        step(16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) gen_step(1'b1, 1'b1);
        tests++; if (err_count !== 8'd99 || err !== 1'b1) begin fails++; $display("FAIL sat_mid got %0d/%b want 99/1", err_count, err); end
        for (int i = 0; i < 201; i++) gen_step(1'b1, 1'b1);
        tests++; if (err_count !== 8'd255 || err !== 1'b1) begin fails++; $display("FAIL sat_final got %0d/%b want 255/1", err_count, err); end
    endtask

    task automatic test_random;
        step(16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) step(16'($urandom), 1'b0, 1'b0);
            else gen_step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            tests++; if (pair_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid %0d got %b want %b", i, pair_valid, q.size() != 0); end
            if (q.size() != 0) begin
                tests++; if (pair_data !== q[0][15:0] || pair_first !== q[0][16]) begin fails++; $display("FAIL rnd_data %0d got %h/%b want %h/%b", i, pair_data, pair_first, q[0][15:0], q[0][16]); end
            end
            tests++; if (err !== m_err || err_count !== 8'(m_cnt) || overflow !== m_ovf) begin fails++; $display("FAIL rnd_status %0d got %b/%0d/%b want %b/%0d/%b", i, err, err_count, overflow, m_err, m_cnt, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_directed(1'b0);
        test_directed(1'b1);
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
